// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg
// Shared definitions for the register file slice: the machine word type,
// the default register address type and the legacy register-file op enum.
// No ports; imported by reg_file_sb and reg_scoreboard.
package reg_file_sb_pkg;

  localparam int WORD_SIZE    = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);

  typedef logic [WORD_SIZE-1:0] word;
  typedef logic [AW_DEF-1:0]    reg_addr_t;

  // Legacy single-issue register file enable. The multi-port file uses
  // wb_valid instead; the type is kept for the older block that still uses it.
  typedef enum logic [1:0] {
    RF_OP_NONE  = 2'b00,
    RF_OP_READ  = 2'b01,
    RF_OP_WRITE = 2'b10,
    RF_OP_RW    = 2'b11
  } reg_file_op_t;

  // True when an address selects a real, writable register (not x0).
  function automatic logic addr_is_live(input logic [31:0] addr);
    return (addr != 32'd0);
  endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard
// Pending-write scoreboard: one busy bit per register, set at issue and
// cleared at writeback, with flush overriding everything. Register 0 is
// never busy. busy_count is the number of set busy bits, kept in a register
// that always mirrors the popcount of the busy vector.
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   issue_valid/issue_addr destination marked busy on this edge
//   wb_valid/wb_addr       destination cleared on this edge
//   flush                  drop every busy mark on this edge
//   busy_vec               current busy bits, one per register
//   busy_count             popcount of busy_vec
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int CW       = $clog2(NUM_REGS + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_addr,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CW-1:0]       busy_count
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_nxt_s;

  // Next busy bit per register: flush, then issue (new producer wins), then writeback.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (!addr_is_live(32'(r))) begin
        busy_nxt_s[r] = 1'b0;
      end else if (flush) begin
        busy_nxt_s[r] = 1'b0;
      end else if (issue_valid && (issue_addr == AW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (wb_valid && (wb_addr == AW'(r))) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Popcount of the next busy vector so the count register tracks busy_r exactly.
  always_comb begin
    count_nxt_s = {CW{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      count_nxt_s = count_nxt_s + CW'(busy_nxt_s[r]);
    end
  end

  // Busy vector and its count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_r  <= {NUM_REGS{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      busy_r  <= busy_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign busy_vec   = busy_r;
  assign busy_count = count_r;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Multi-read-port register file with same-cycle writeback bypass and a
// per-register pending-write scoreboard. x0 reads as zero and is never busy.
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   rd_addr             NUM_READ packed read addresses (port p at [p*AW +: AW])
//   rd_data             NUM_READ packed read values (port p at [p*WORD_SIZE +: WORD_SIZE])
//   rd_busy             per port: operand still has an outstanding write
//   wb_valid/addr/data  writeback of a result
//   issue_valid/addr    destination marked busy by an issuing instruction
//   flush               clear all busy marks
//   busy_count          number of registers currently busy
module reg_file_sb #(
  parameter int WORD_SIZE = reg_file_sb_pkg::WORD_SIZE,
  parameter int NUM_REGS  = 32,
  parameter int NUM_READ  = 2,
  parameter int AW        = $clog2(NUM_REGS)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_READ*AW-1:0]        rd_addr,
  output logic [NUM_READ*WORD_SIZE-1:0] rd_data,
  output logic [NUM_READ-1:0]           rd_busy,
  input  logic                          wb_valid,
  input  logic [AW-1:0]                 wb_addr,
  input  logic [WORD_SIZE-1:0]          wb_data,
  input  logic                          issue_valid,
  input  logic [AW-1:0]                 issue_addr,
  input  logic                          flush,
  output logic [$clog2(NUM_REGS+1)-1:0] busy_count
);

  import reg_file_sb_pkg::*;

  localparam int CW = $clog2(NUM_REGS + 1);

  logic [WORD_SIZE-1:0] regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_vec_s;
  logic                 wb_live_s;

  assign wb_live_s = wb_valid && addr_is_live(32'(wb_addr));

  // Data array: writeback lands regardless of busy state or flush; x0 is never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= {WORD_SIZE{1'b0}};
      end
    end else if (wb_live_s) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r[0] <= {WORD_SIZE{1'b0}};
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .CW       (CW)
  ) u_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .flush       (flush),
    .busy_vec    (busy_vec_s),
    .busy_count  (busy_count)
  );

  // Read ports. A same-cycle writeback is forwarded and reported not busy,
  // since its producer has just finished. A same-cycle issue is younger than
  // the reader and so is deliberately invisible here.
  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [AW-1:0]        addr_s;
    logic [WORD_SIZE-1:0] data_s;
    logic                 busy_s;

    assign addr_s = rd_addr[p*AW +: AW];

    // Operand select for this port: x0, bypass, then stored value.
    always_comb begin
      data_s = {WORD_SIZE{1'b0}};
      busy_s = 1'b0;
      if (!addr_is_live(32'(addr_s))) begin
        data_s = {WORD_SIZE{1'b0}};
        busy_s = 1'b0;
      end else if (wb_valid && (wb_addr == addr_s)) begin
        data_s = wb_data;
        busy_s = 1'b0;
      end else begin
        data_s = regs_r[addr_s];
        busy_s = busy_vec_s[addr_s];
      end
    end

    assign rd_data[p*WORD_SIZE +: WORD_SIZE] = data_s;
    assign rd_busy[p]                        = busy_s;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
// Two instances driven by the same stimulus: A is the default 32x32, 2-port
// file; B is 16 registers, 3 ports, 64-bit words (addresses reduced mod 16).
// A behavioural model (plain arrays) predicts every output and is compared
// on each falling edge; literal checks pin the key scenarios.
`timescale 1ns/1ps
module tb_reg_file_sb;

  logic        clock;
  logic        reset_n;
  logic        wb_valid, issue_valid, flush;
  logic [4:0]  wa, ia;
  logic [63:0] wd;
  logic [4:0]  ra [3];

  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [5:0]  busy_count_a;

  logic [11:0]  rd_addr_b;
  logic [191:0] rd_data_b;
  logic [2:0]   rd_busy_b;
  logic [4:0]   busy_count_b;

  int n_checks;
  int n_fail;
  bit chk_en;

  logic [63:0] m_regs [2][32];
  bit          m_busy [2][32];

  assign rd_addr_a = {ra[1], ra[0]};
  assign rd_addr_b = {ra[2][3:0], ra[1][3:0], ra[0][3:0]};

  reg_file_sb #(.WORD_SIZE(32), .NUM_REGS(32), .NUM_READ(2)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .rd_busy(rd_busy_a), .wb_valid(wb_valid), .wb_addr(wa), .wb_data(wd[31:0]),
    .issue_valid(issue_valid), .issue_addr(ia), .flush(flush), .busy_count(busy_count_a)
  );

  reg_file_sb #(.WORD_SIZE(64), .NUM_REGS(16), .NUM_READ(3)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wb_valid(wb_valid), .wb_addr(wa[3:0]), .wb_data(wd),
    .issue_valid(issue_valid), .issue_addr(ia[3:0]), .flush(flush), .busy_count(busy_count_b)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mapa(input int d, input logic [4:0] a);
    return (d == 0) ? int'(a) : int'(a[3:0]);
  endfunction

  // Model state update on each edge, cleared asynchronously by reset.
  always @(posedge clock or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[d][r] <= 64'd0;
          m_busy[d][r] <= 1'b0;
        end
      end else begin
        if (wb_valid && mapa(d, wa) != 0) m_regs[d][mapa(d, wa)] <= wd;
        if (flush) begin
          for (int r = 0; r < 32; r++) m_busy[d][r] <= 1'b0;
        end else begin
          if (wb_valid && mapa(d, wa) != 0) m_busy[d][mapa(d, wa)] <= 1'b0;
          if (issue_valid && mapa(d, ia) != 0) m_busy[d][mapa(d, ia)] <= 1'b1;
        end
      end
    end
  end

  // Compare every output of both instances against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int cnt;
        cnt = 0;
        for (int r = 0; r < 32; r++) cnt += int'(m_busy[d][r]);
        for (int p = 0; p < ((d == 0) ? 2 : 3); p++) begin
          int          a;
          logic [63:0] ed, ad;
          bit          eb, ab;
          a = mapa(d, ra[p]);
          if (a == 0) begin
            ed = 64'd0; eb = 1'b0;
          end else if (wb_valid && mapa(d, wa) == a) begin
            ed = wd; eb = 1'b0;
          end else begin
            ed = m_regs[d][a]; eb = m_busy[d][a];
          end
          if (d == 0) begin
            ed = {32'd0, ed[31:0]};
            ad = {32'd0, rd_data_a[p*32 +: 32]};
            ab = rd_busy_a[p];
          end else begin
            ad = rd_data_b[p*64 +: 64];
            ab = rd_busy_b[p];
          end
          chk($sformatf("dut%0d_rd_data%0d", d, p), ad, ed);
          chk($sformatf("dut%0d_rd_busy%0d", d, p), 64'(ab), 64'(eb));
        end
        chk($sformatf("dut%0d_busy_count", d),
            (d == 0) ? 64'(busy_count_a) : 64'(busy_count_b), 64'(cnt));
      end
    end
  end

  task automatic step(input bit wbv, input logic [4:0] a_wb, input logic [63:0] d_wb,
                      input bit iv, input logic [4:0] a_is, input bit fl,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clock);
    #2;
    wb_valid = wbv; wa = a_wb; wd = d_wb;
    issue_valid = iv; ia = a_is; flush = fl;
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    reset_n = 1'b0;
    wb_valid = 1'b0; wa = 5'd0; wd = 64'd0;
    issue_valid = 1'b0; ia = 5'd0; flush = 1'b0;
    ra[0] = 5'd0; ra[1] = 5'd0; ra[2] = 5'd0;
    #1;
    chk("lit_reset_rd_data", rd_data_a, 64'd0);
    chk("lit_reset_count", 64'(busy_count_a), 64'd0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;

    // Reset mid-cycle wipes stored data at once.
    step(1'b1, 5'd5, 64'hCAFEF00D_DEADBEEF, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 5'd0);
    chk("lit_bypass_x5_a", 64'(rd_data_a[31:0]), 64'h0000_0000_DEAD_BEEF);
    chk("lit_bypass_x5_b", rd_data_b[63:0], 64'hCAFEF00D_DEADBEEF);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 5'd0);
    chk("lit_stored_x5", 64'(rd_data_a[31:0]), 64'h0000_0000_DEAD_BEEF);
    #1 reset_n = 1'b0;
    #1;
    chk("lit_async_reset_a", 64'(rd_data_a[31:0]), 64'd0);
    chk("lit_async_reset_b", rd_data_b[63:0], 64'd0);
    chk("lit_async_reset_count", 64'(busy_count_a), 64'd0);
    #1 reset_n = 1'b1;

    // Bypass on x7.
    step(1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 5'd0);
    chk("lit_bypass_x7", 64'(rd_data_a[31:0]), 64'h1234);
    chk("lit_bypass_x7_busy", 64'(rd_busy_a[0]), 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 5'd0);
    chk("lit_stored_x7", 64'(rd_data_a[31:0]), 64'h1234);

    // Scoreboard set and clear on x3.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0, 5'd0);
    chk("lit_same_cycle_issue", 64'(rd_busy_a[0]), 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd0);
    chk("lit_x3_busy", 64'(rd_busy_a[0]), 64'd1);
    chk("lit_x3_count", 64'(busy_count_a), 64'd1);
    step(1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd0, 5'd0);
    chk("lit_x3_cleared", 64'(rd_busy_a[0]), 64'd0);
    chk("lit_x3_count0", 64'(busy_count_a), 64'd0);

    // Issue and writeback collide on busy x9.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 5'd0);
    step(1'b1, 5'd9, 64'hAA, 1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 5'd0);
    chk("lit_x9_data", 64'(rd_data_a[31:0]), 64'hAA);
    chk("lit_x9_busy", 64'(rd_busy_a[0]), 64'd1);
    chk("lit_x9_count", 64'(busy_count_a), 64'd1);
    step(1'b1, 5'd9, 64'hAA, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Flush with a concurrent issue and writeback.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2, 5'd4);
    chk("lit_three_busy", 64'(busy_count_a), 64'd3);
    step(1'b1, 5'd2, 64'h77, 1'b1, 5'd6, 1'b1, 5'd2, 5'd6, 5'd4);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd6, 5'd4);
    chk("lit_flush_count", 64'(busy_count_a), 64'd0);
    chk("lit_flush_x2", 64'(rd_data_a[31:0]), 64'h77);

    // x0 ignores writes and issues.
    step(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("lit_x0_bypass", rd_data_b[63:0], 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("lit_x0_count", 64'(busy_count_b), 64'd0);

    // All ports read the same busy register.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd11, 1'b0, 5'd11, 5'd11, 5'd11);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd11, 5'd11, 5'd11);
    chk("lit_b_all_busy", 64'(rd_busy_b), 64'h7);
    step(1'b1, 5'd11, 64'h0123456789ABCDEF, 1'b0, 5'd0, 1'b0, 5'd11, 5'd11, 5'd11);
    chk("lit_b_bypass_p2", rd_data_b[191:128], 64'h0123456789ABCDEF);

    // Top register on A (aliases to x15 on B).
    step(1'b1, 5'd31, 64'h3131, 1'b1, 5'd31, 1'b0, 5'd31, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd31, 5'd0, 5'd0);
    chk("lit_x31_data", 64'(rd_data_a[31:0]), 64'h3131);
    chk("lit_x31_busy", 64'(rd_busy_a[0]), 64'd1);

    // Flush, issue and writeback all to x12.
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 1'b0, 5'd12, 5'd0, 5'd0);
    step(1'b1, 5'd12, 64'hC0C0, 1'b1, 5'd12, 1'b1, 5'd12, 5'd0, 5'd0);
    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd12, 5'd31, 5'd12);
    chk("lit_x12_data", 64'(rd_data_a[31:0]), 64'hC0C0);
    chk("lit_x12_busy", 64'(rd_busy_a[0]), 64'd0);
    chk("lit_x12_count", 64'(busy_count_a), 64'd0);

    // Deterministic mixed traffic, checked by the model only.
    for (int i = 0; i < 48; i++) begin
      step(((i % 3) != 0), 5'((i * 7) % 32), {32'(i * 32'h1111), 32'(i * 32'h0101_0101)},
           ((i % 2) == 0), 5'((i * 5 + 3) % 32), ((i % 13) == 12),
           5'((i * 5 + 3) % 32), 5'((i * 7) % 32), 5'((i * 3) % 32));
    end

    step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with same-cycle writeback bypass and a per-register pending-write scoreboard. It replaces the single-issue register file in the pipelined core. Decode reads operands and marks the destination busy at issue; writeback writes the result and clears busy. Hazard logic stalls on the per-port busy flags, and a flush drops all pending marks after a branch mispredict or trap.

## Interface
Parameters:
- WORD_SIZE, 32, data width in bits (from the shared package).
- NUM_REGS, 32, register count; power of two, ≥ 2.
- NUM_READ, 2, read port count, 1 to 4.
- AW, $clog2(NUM_REGS), address width (derived; not to be overridden).

Ports:
- clock  in  1  — single clock, rising edge.
- reset_n  in  1  — asynchronous, active-low reset.
- rd_addr  in  NUM_READ×AW  — read addresses, one per port.
- rd_data  out  NUM_READ×WORD_SIZE  — read data, one per port.
- rd_busy  out  NUM_READ  — per port: the operand has an outstanding write.
- wb_valid  in  1  — writeback strobe.
- wb_addr  in  AW  — writeback destination.
- wb_data  in  WORD_SIZE  — writeback value.
- issue_valid  in  1  — an instruction with a destination register issues this cycle.
- issue_addr  in  AW  — destination to mark busy.
- flush  in  1  — clear all busy marks.
- busy_count  out  $clog2(NUM_REGS+1)  — number of registers currently busy.

## Operation
- Register 0 always reads 0 and is never busy. Writes and issues to address 0 are ignored.
- Reads are combinational, evaluated in this order for each port p:
  - rd_addr[p] == 0: rd_data 0, rd_busy 0.
  - wb_valid && wb_addr == rd_addr[p]: rd_data = wb_data (bypass), rd_busy 0.
  - Otherwise: rd_data = stored value, rd_busy = busy[rd_addr[p]].
- Issue in the same cycle does not affect rd_busy. The reading instruction is older than the issuing one.
- Data write: on the clock edge with wb_valid and wb_addr ≠ 0, the register takes wb_data. This happens whether or not the register is busy, and whether or not flush is asserted.
- Busy update per register r ≠ 0, highest priority first:
  1. flush → 0.
  2. issue_valid && issue_addr == r → 1. This holds even if writeback hits r in the same cycle, because the new producer wins.
  3. wb_valid && wb_addr == r → 0.
  4. Otherwise hold.
- Writeback to a non-busy register is legal and leaves busy at 0.
- busy_count is the combinational popcount of the busy register.

## Timing
- Async reset (reset_n low): all registers 0 and all busy 0, immediately and independent of clock. Outputs then read rd_data 0, rd_busy 0, busy_count 0, except that wb bypass still applies combinationally.
- Read latency is 0 cycles. Write-to-read latency is 0 cycles through the bypass; stored data is visible on the cycle after the edge.
- Issue-to-busy latency is 1 edge. Writeback-to-clear latency is 1 edge, but it is masked in the same cycle by the bypass.
- Reset deassertion mid-stream: the first edge after deassertion applies normal updates. There is no holdoff cycle.
- Simultaneous flush, issue and wb to the same r: the data is written and busy ends at 0.

## Structure
- Shared package (params.sv):
  - `word` typedef and WORD_SIZE.
  - A `reg_addr_t` typedef, logic [AW-1:0] for the default 32 registers.
- The `reg_file_op_t` enable is superseded here by wb_valid; the old type stays in the package for the legacy block.
- One natural sub-module: `reg_scoreboard`, holding the busy vector, its update priority and the popcount. The data array and bypass muxes stay in the top.
- Read ports are a generate loop over NUM_READ.

## Test plan
- Reset: write 0xDEADBEEF to x5, then pulse reset_n low between edges. rd_data for x5 reads 0 at once, busy_count reads 0.
- Bypass: wb_valid, wb_addr=7, wb_data=0x1234 with rd_addr[0]=7. rd_data[0]=0x1234 and rd_busy[0]=0 in the same cycle; the stored value of x7 is 0x1234 after the edge.
- Scoreboard: issue x3, then one cycle later read x3. rd_busy=1, busy_count=1. Writeback x3=0x55, and after that edge rd_busy=0, busy_count=0.
- Collision: x9 is busy; issue x9 and wb x9=0xAA in the same cycle. After the edge x9 holds 0xAA with busy=1, busy_count unchanged.
- Flush: issue x1, x2 and x4, then flush together with issue x6 and wb x2=0x77. After the edge busy_count=0 and x2 holds 0x77.
- x0 and parameters: wb/issue to x0 leaves rd_data 0, busy 0. Repeat the suite at NUM_REGS=16, NUM_READ=3, WORD_SIZE=64 with all three ports reading the same busy register.
